// File: rtl/adder_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// adder_arbiter_pkg
// Shared defaults and helpers for the shared-adder round-robin arbiter.
//   DEF_N  : default requester count
//   DEF_W  : default operand / sum width
//   clog2  : ceiling log2, used to size the requester id
// -----------------------------------------------------------------------------
package adder_arbiter_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 8;

    // Constant function so the id width can be derived in a parameter list.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : adder_arbiter_pkg

// File: rtl/adder_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin select. Scans req_i starting at ptr_i, wrapping
// modulo N, and returns the first asserted requester.
//   req_i  : eligible requests
//   ptr_i  : index to start searching from (always < N)
//   gnt_o  : one-hot winner (all-zero when nothing is requested)
//   idx_o  : encoded winner index (0 when nothing is requested)
//   any_o  : a winner exists
// -----------------------------------------------------------------------------
module rr_picker
    import adder_arbiter_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int IDW = clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] idx_o,
    output logic           any_o
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDW'(j);
            end
        end
    end

endmodule : rr_picker

// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
// One W-bit adder shared by N requesters under round-robin arbitration. The
// granted requester's {carry, sum} and its id land in a single-entry result
// buffer with valid/ready handshake. A per-requester carry flag lets each
// requester chain multi-word additions, least significant word first.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req/lock/chain      : per-requester request, pointer lock, carry-chain enable
//   a_in, b_in          : packed operands, requester i at [i*W +: W]
//   gnt                 : combinational one-hot grant (operands consumed at edge)
//   res_valid/res_ready : result buffer handshake
//   res_sum/res_cy/res_id : buffered result
//   cflag               : stored carry per requester
// -----------------------------------------------------------------------------
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int W   = DEF_W,
    parameter int IDW = clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   lock,
    input  logic [N-1:0]   chain,
    input  logic [N*W-1:0] a_in,
    input  logic [N*W-1:0] b_in,
    output logic [N-1:0]   gnt,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [W-1:0]   res_sum,
    output logic           res_cy,
    output logic [IDW-1:0] res_id,
    output logic [N-1:0]   cflag
);

    logic           res_valid_q, res_valid_d;
    logic [W-1:0]   res_sum_q,   res_sum_d;
    logic           res_cy_q,    res_cy_d;
    logic [IDW-1:0] res_id_q,    res_id_d;
    logic [N-1:0]   cflag_q,     cflag_d;
    logic [IDW-1:0] ptr_q,       ptr_d;

    logic           can_accept;
    logic [N-1:0]   req_elig;
    logic [N-1:0]   pick_oh;
    logic [IDW-1:0] g;
    logic           grant;
    logic [W-1:0]   a_g, b_g;
    logic           cin;
    logic [W:0]     sum_full;
    logic [IDW-1:0] ptr_next;

    // Buffer is free when empty or being drained this cycle. Gating with rst_n
    // keeps gnt low for the whole reset, not just once the flops have cleared.
    assign can_accept = !res_valid_q || res_ready;
    assign req_elig   = (can_accept && rst_n) ? req : '0;

    rr_picker #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_picker (
        .req_i (req_elig),
        .ptr_i (ptr_q),
        .gnt_o (pick_oh),
        .idx_o (g),
        .any_o (grant)
    );

    assign gnt = pick_oh;

    // Shared datapath: carry-in only when the winner asks to chain.
    assign a_g      = a_in[int'(g)*W +: W];
    assign b_g      = b_in[int'(g)*W +: W];
    assign cin      = chain[g] & cflag_q[g];
    assign sum_full = {1'b0, a_g} + {1'b0, b_g} + {{W{1'b0}}, cin};

    // Explicit wrap so non-power-of-two N never lands on an unused index.
    assign ptr_next = (int'(g) == N - 1) ? '0 : g + 1'b1;

    always_comb begin
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_cy_d    = res_cy_q;
        res_id_d    = res_id_q;
        cflag_d     = cflag_q;
        ptr_d       = ptr_q;
        if (grant) begin
            // A grant while the old result is being drained overwrites it,
            // sustaining one add per cycle.
            res_valid_d = 1'b1;
            res_sum_d   = sum_full[W-1:0];
            res_cy_d    = sum_full[W];
            res_id_d    = g;
            cflag_d[g]  = sum_full[W];
            ptr_d       = lock[g] ? g : ptr_next;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge value of every other register, independent of code order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_cy_q    <= 1'b0;
            res_id_q    <= '0;
            cflag_q     <= '0;
            ptr_q       <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_cy_q    <= res_cy_d;
            res_id_q    <= res_id_d;
            cflag_q     <= cflag_d;
            ptr_q       <= ptr_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_cy    = res_cy_q;
    assign res_id    = res_id_q;
    assign cflag     = cflag_q;

endmodule : adder_arbiter

// File: tb/tb_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_arbiter
// Scoreboard bench for adder_arbiter. The driver keeps a behavioural model
// (pointer as an integer, carry flags, buffer occupancy) and pushes each
// expected result into a queue when it predicts a grant; a monitor pops and
// compares whenever the DUT hands over a result.
// -----------------------------------------------------------------------------
module tb_adder_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           cy;
        logic [W-1:0]   sum;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req, lock, chain;
    logic [N*W-1:0] a_in, b_in;
    logic [N-1:0]   gnt;
    logic           res_valid, res_ready;
    logic [W-1:0]   res_sum;
    logic           res_cy;
    logic [IDW-1:0] res_id;
    logic [N-1:0]   cflag;

    adder_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .chain     (chain),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cy    (res_cy),
        .res_id    (res_id),
        .cflag     (cflag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    exp_t sb[$];
    exp_t mon_e;

    // Reference model state
    int           m_ptr;
    logic [N-1:0] m_cflag;
    bit           m_valid;
    int           m_last_g;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [N*W-1:0] ops(input logic [W-1:0] x3, x2, x1, x0);
        return {x3, x2, x1, x0};
    endfunction

    function automatic logic [W-1:0] rand_op();
        int unsigned r;
        r = $urandom_range(7);
        if (r < 2) return 8'hFF;
        if (r == 2) return 8'h00;
        return W'($urandom_range(255));
    endfunction

    task automatic model_reset();
        m_ptr    = 0;
        m_cflag  = '0;
        m_valid  = 0;
        m_last_g = -1;
        sb.delete();
    endtask

    // Called shortly after a rising edge: drive inputs, predict and check
    // this cycle's grant, advance the model, then move to the next cycle.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N-1:0] c,
                        input logic [N*W-1:0] a, input logic [N*W-1:0] b, input logic rdy);
        int   g;
        int   s;
        int   cin;
        bit   can;
        exp_t e;
        req = r; lock = l; chain = c; a_in = a; b_in = b; res_ready = rdy;
        #3;
        can = !m_valid || rdy;
        g   = -1;
        if (can) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && r[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        check("res_valid", 32'(res_valid), 32'(m_valid));
        check("cflag", 32'(cflag), 32'(m_cflag));
        check("gnt", 32'(gnt), (g >= 0) ? (32'd1 << g) : 32'd0);
        if (g >= 0) begin
            cin = (c[g] && m_cflag[g]) ? 1 : 0;
            s   = int'(a[g*W +: W]) + int'(b[g*W +: W]) + cin;
            e.id  = IDW'(g);
            e.cy  = (s >= 256);
            e.sum = W'(s % 256);
            sb.push_back(e);
            m_cflag[g] = e.cy;
            m_ptr      = l[g] ? g : (g + 1) % N;
            m_valid    = 1;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        m_last_g = g;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step('0, '0, '0, '0, '0, rdy);
    endtask

    // Asynchronous reset applied mid-cycle, with requests pending.
    task automatic mid_reset();
        req = '1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_cflag", 32'(cflag), 32'd0);
        model_reset();
        req = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: one handover per cycle where valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got id=%0d sum=0x%0h with empty queue", res_id, res_sum);
            end else begin
                mon_e = sb.pop_front();
                check("result", 32'({res_id, res_cy, res_sum}), 32'(mon_e));
            end
        end
    end

    logic [N-1:0]   pend, rl, rc;
    logic [N*W-1:0] ra, rb;

    initial begin
        rst_n = 1'b0; req = 4'b0001; lock = '0; chain = '0;
        a_in = '0; b_in = '0; res_ready = 1'b1;
        model_reset();
        #12;
        check("init_gnt", 32'(gnt), 32'd0);
        check("init_res_valid", 32'(res_valid), 32'd0);
        req = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request: 10 + 5
        step(4'b0001, '0, '0, ops(0, 0, 0, 8'd10), ops(0, 0, 0, 8'd5), 1'b1);
        idle(1'b1);

        // Overflow on requester 2: 255 + 128
        step(4'b0100, '0, '0, ops(0, 8'd255, 0, 0), ops(0, 8'd128, 0, 0), 1'b1);
        idle(1'b1);

        // Fairness: everyone requesting, no lock
        for (int i = 0; i < 5; i++)
            step(4'b1111, '0, '0, ops(8'd4, 8'd3, 8'd2, 8'd1), ops(8'd40, 8'd30, 8'd20, 8'd10), 1'b1);
        idle(1'b1);

        // Locked, chained 16-bit add on requester 1: 0x00FF + 0x0001
        step(4'b0010, 4'b0010, '0, ops(0, 0, 8'hFF, 0), ops(0, 0, 8'h01, 0), 1'b1);
        step(4'b1011, 4'b0010, 4'b0010, ops(8'h11, 0, 8'h00, 8'h22), ops(8'h11, 0, 8'h00, 8'h22), 1'b1);
        idle(1'b1);

        // All-ones with carry-in on requester 3
        step(4'b1000, 4'b1000, '0, ops(8'hFF, 0, 0, 0), ops(8'hFF, 0, 0, 0), 1'b1);
        step(4'b1000, '0, 4'b1000, ops(8'hFF, 0, 0, 0), ops(8'hFF, 0, 0, 0), 1'b1);
        idle(1'b1);

        // Backpressure: fill the buffer, stall three cycles, then resume
        step(4'b0001, '0, '0, ops(0, 0, 0, 8'd7), ops(0, 0, 0, 8'd8), 1'b1);
        for (int i = 0; i < 3; i++)
            step(4'b1111, '0, '0, ops(8'd9, 8'd8, 8'd7, 8'd6), ops(8'd1, 8'd2, 8'd3, 8'd4), 1'b0);
        step(4'b1111, '0, '0, ops(8'd9, 8'd8, 8'd7, 8'd6), ops(8'd1, 8'd2, 8'd3, 8'd4), 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Reset while a result is parked, then check the pointer restarts at 0
        step(4'b0100, '0, '0, ops(0, 8'hF0, 0, 0), ops(0, 8'h20, 0, 0), 1'b1);
        idle(1'b0);
        mid_reset();
        step(4'b1111, '0, '0, ops(8'd1, 8'd1, 8'd1, 8'd1), ops(8'd2, 8'd2, 8'd2, 8'd2), 1'b1);
        idle(1'b1);

        // Randomized traffic honouring the hold-until-granted rule
        pend = '0; rl = '0; rc = '0; ra = '0; rb = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                bit dropped;
                dropped = 0;
                if (pend[i] && m_last_g == i) begin
                    pend[i] = 1'b0;
                end else if (pend[i] && $urandom_range(15) == 0) begin
                    pend[i] = 1'b0;
                    dropped = 1;
                end
                if (!pend[i] && !dropped && $urandom_range(1) == 1) begin
                    pend[i]       = 1'b1;
                    ra[i*W +: W]  = rand_op();
                    rb[i*W +: W]  = rand_op();
                    rc[i]         = ($urandom_range(1) == 1);
                    rl[i]         = ($urandom_range(3) == 0);
                end
            end
            step(pend, rl, rc, ra, rb, ($urandom_range(3) != 0));
        end

        idle(1'b1);
        idle(1'b1);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_adder_arbiter
